alu_share_arbiter: RTL and testbench

// - Shares one combinational 16-bit ALU (4-bit opcode, opA/opB, Result, carry_out, ALU_en) between NREQ requesters.
// - Requesters are e.g. the FIR tap MAC sequencer, coefficient loader and debug port.
// - Round-robin arbitration with valid/ready requests; one registered response bus carries result, carry, error and requester id.
// - Sits between the filter control logic and the ALU instance; this block is the ALU's only driver.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_share_arbiter_rr_arbiter.sv | 30 +++
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: opcode map, FSM encoding and
// the fixed divide-by-zero result.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_LT  = 4'hC;
  localparam logic [3:0] OP_GT  = 4'hD;
  localparam logic [3:0] OP_NE  = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// reported both as a one-hot grant and as an index.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters with round-robin
// arbitration and a single registered response bus.
//
//   state | meaning
//   IDLE  | no operation in flight, accepting requests
//   EXEC  | operands on the ALU, result captured at end of cycle
//   RESP  | response held until consumer takes it; may accept the next request
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [3:0]        alu_opcode,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic              alu_en,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       op_count
);

  state_t          state;
  logic [IDW-1:0]  last;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic            can_accept;
  logic            accept;
  logic            div0_in;
  logic            div0_exec;
  logic [3:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign accept     = can_accept && grant_any;
  // Held low during reset so every output reads zero while rst is asserted.
  assign req_ready  = (can_accept && !rst) ? grant : '0;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    int gi;
    gi     = int'(grant_idx);
    sel_op = req_op[4*gi +: 4];
    sel_a  = req_a[W*gi +: W];
    sel_b  = req_b[W*gi +: W];
  end

  assign div0_in   = (sel_op == OP_DIV) && (sel_b == '0);
  // Operand registers still hold the executing op, so the flag is recomputed here.
  assign div0_exec = (alu_opcode == OP_DIV) && (alu_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last       <= IDW'(NREQ - 1);
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      alu_en <= 1'b0;
      case (state)
        ST_IDLE: ;
        ST_EXEC: begin
          if (div0_exec) begin
            rsp_result <= W'(DIV0_RESULT);
            rsp_carry  <= 1'b0;
          end else begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
          end
          rsp_err   <= div0_exec;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Accept overrides the next state chosen above (IDLE or RESP handshake).
      if (accept) begin
        alu_opcode <= sel_op;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_en     <= !div0_in;
        rsp_id     <= grant_idx;
        last       <= grant_idx;
        state      <= ST_EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a transaction-level
// model; the bench also plays the role of the shared ALU.
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [3:0]        alu_opcode;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic              alu_en;
  logic [W-1:0]      alu_result;
  logic              alu_carry;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_carry;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       op_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        c;
    logic        e;
    int          t;
  } exp_t;

  exp_t q[$];

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Bench ALU; divide by zero returns a marker so a missing bypass is visible.
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [31:0] p;
    case (op)
      4'h0: alu_fn = {1'b0, a} + {1'b0, b};
      4'h1: alu_fn = {1'b0, a} - {1'b0, b};
      4'h2: begin p = a * b; alu_fn = {1'b0, p[15:0]}; end
      4'h3: alu_fn = (b == 16'h0) ? 17'h1_1234 : {1'b0, a / b};
      default: alu_fn = {op[0], a ^ b ^ {12'h0, op}};
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_valid[i]      = 1'b1;
    req_op[4*i +: 4]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          last_m;
    int          cnt_m;
    int          g;
    int          idx;
    logic        has, exp_rv, exp_en, can;
    logic [3:0]  exp_ready;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [16:0] r;
    exp_t        e;

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_en", alu_en, 0);
    chk("rst_result", rsp_result, 0);
    rst = 1'b0;

    // Round robin from reset: grant order 0,1,2,3,0, one accept per 2 cycles.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'h0, 16'(i * 256), 16'h1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", req_ready, 1 << (k % 4));
      if (k > 0) begin
        chk("rr_id", rsp_id, (k - 1) % 4);
        chk("rr_result", rsp_result, ((k - 1) % 4) * 256 + 1);
      end
      cyc();
      if (k == 4) req_valid = '0;
      if (k > 0) chk("rr_count", op_count, k);
      chk("rr_en", alu_en, 1);
      cyc();
    end
    chk("rr_last_id", rsp_id, 0);
    cyc();
    chk("rr_count5", op_count, 5);
    chk("rr_idle", busy, 0);

    // Basic add, two-cycle latency.
    set_req(0, 4'h0, 16'h0003, 16'h0004);
    #1 chk("add_ready", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    chk("add_en", alu_en, 1);
    chk("add_nvalid", rsp_valid, 0);
    cyc();
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 16'h0007);
    chk("add_carry", rsp_carry, 0);
    chk("add_id", rsp_id, 0);
    chk("add_err", rsp_err, 0);
    cyc();
    chk("add_done", rsp_valid, 0);
    chk("add_count", op_count, 6);

    // Carry out of 0xFFFF + 1.
    set_req(2, 4'h0, 16'hFFFF, 16'h0001);
    #1 chk("carry_ready", req_ready, 4'b0100);
    cyc(); req_valid = '0;
    cyc();
    chk("carry_result", rsp_result, 16'h0000);
    chk("carry_carry", rsp_carry, 1);
    chk("carry_id", rsp_id, 2);
    cyc();

    // Divide by zero, then a legal divide back to back.
    set_req(1, 4'h3, 16'h0010, 16'h0000);
    #1 chk("div0_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    chk("div0_en", alu_en, 0);
    chk("div0_busy", busy, 1);
    cyc();
    chk("div0_result", rsp_result, 16'hFFFF);
    chk("div0_err", rsp_err, 1);
    chk("div0_carry", rsp_carry, 0);
    chk("div0_id", rsp_id, 1);
    chk("div0_en2", alu_en, 0);
    set_req(1, 4'h3, 16'h0010, 16'h0004);
    #1 chk("div_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    chk("div_en", alu_en, 1);
    chk("div_nvalid", rsp_valid, 0);
    chk("div_err_held", rsp_err, 1);
    cyc();
    chk("div_result", rsp_result, 16'h0004);
    chk("div_err", rsp_err, 0);
    cyc();

    // Consumer stalls for 5 cycles with req3 pending.
    rsp_ready = 1'b0;
    set_req(0, 4'h0, 16'h0003, 16'h0004);
    #1 chk("hold_ready0", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    set_req(3, 4'h0, 16'h0005, 16'h0006);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, 16'h0007);
      chk("hold_id", rsp_id, 0);
      chk("hold_noready", req_ready, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("hold_ready3", req_ready, 4'b1000);
    cyc(); req_valid = '0;
    chk("hold_en", alu_en, 1);
    chk("hold_nvalid", rsp_valid, 0);
    chk("hold_count", op_count, 10);
    cyc();
    chk("hold_result3", rsp_result, 16'h000B);
    chk("hold_id3", rsp_id, 3);
    cyc();

    // Reset in the middle of EXEC.
    set_req(2, 4'h1, 16'h0005, 16'h0003);
    cyc(); req_valid = '0;
    chk("mid_en", alu_en, 1);
    rst = 1'b1;
    #1;
    chk("mrst_en", alu_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_count", op_count, 0);
    chk("mrst_a", alu_a, 0);
    chk("mrst_op", alu_opcode, 0);
    chk("mrst_id", rsp_id, 0);
    set_req(0, 4'h0, 16'h1, 16'h1);
    set_req(1, 4'h0, 16'h2, 16'h2);
    #1 chk("mrst_ready", req_ready, 0);
    cyc();
    rst = 1'b0;
    #1 chk("mrst_first", req_ready, 4'b0001);
    rst = 1'b1; req_valid = '0;
    cyc(); cyc();
    rst = 1'b0;

    // Randomized traffic against a transaction-level model.
    last_m = NREQ - 1;
    cnt_m  = 0;
    for (int n = 0; n < 400; n++) begin
      if (n < 380) begin
        req_valid = 4'($urandom);
        for (int i = 0; i < NREQ; i++) begin
          op = ($urandom_range(0, 2) == 0) ? 4'h3 : 4'($urandom);
          b  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          req_op[4*i +: 4]  = op;
          req_a[16*i +: 16] = 16'($urandom);
          req_b[16*i +: 16] = b;
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      #1;
      has    = (q.size() > 0);
      exp_rv = 1'b0;
      exp_en = 1'b0;
      if (has) begin
        exp_rv = (n >= q[0].t + 2);
        exp_en = (n == q[0].t + 1) && !q[0].e;
      end
      can = !has || (exp_rv && rsp_ready);
      g   = -1;
      if (can) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (last_m + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'h0;
      chk("r_valid", rsp_valid, exp_rv);
      chk("r_ready", req_ready, exp_ready);
      chk("r_en", alu_en, exp_en);
      chk("r_busy", busy, has);
      chk("r_count", op_count, 16'(cnt_m));
      if (exp_rv) begin
        chk("r_id", rsp_id, q[0].id);
        chk("r_result", rsp_result, q[0].res);
        chk("r_carry", rsp_carry, q[0].c);
        chk("r_err", rsp_err, q[0].e);
      end
      if (exp_rv && rsp_ready) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (g >= 0) begin
        op = req_op[4*g +: 4];
        a  = req_a[16*g +: 16];
        b  = req_b[16*g +: 16];
        e.id = g;
        e.t  = n;
        if (op == 4'h3 && b == 16'h0) begin
          e.res = 16'hFFFF; e.c = 1'b0; e.e = 1'b1;
        end else begin
          r = alu_fn(op, a, b);
          e.res = r[15:0]; e.c = r[16]; e.e = 1'b0;
        end
        q.push_back(e);
        last_m = g;
      end
      @(posedge clk);
      #1;
    end
    chk("r_drained", q.size(), 0);
    chk("r_final_count", op_count, 16'(cnt_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
